// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the datapath and the data-memory responder.
interface data_mem_responder_if;
  logic        en;
  logic        rw;
  logic [15:0] addr;
  logic [15:0] A;
  logic [15:0] Q;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output en, rw, addr, A,
    input  Q, ack, err, busy
  );

  modport slave (
    input  en, rw, addr, A,
    output Q, ack, err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures a level-held request, waits LATENCY cycles,
// performs the access and pulses ack for one cycle with read data and an error flag.
module data_mem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic        rw_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        err_q;
  logic        capture;
  logic        access;
  logic        in_range;

  logic [15:0] mem [DEPTH];

  assign in_range = 32'(addr_q) < DEPTH;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          state_d = StWait;
          cnt_d   = 4'(LATENCY - 1);
          capture = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= bus.addr;
        rw_q    <= bus.rw;
        wdata_q <= bus.A;
      end
      if (access) begin
        err_q <= ~in_range;
        if (!rw_q) begin
          rdata_q <= in_range ? mem[addr_q[ADDR_BITS-1:0]] : 16'h0000;
        end
      end else if (state_q == StAck) begin
        err_q <= 1'b0;
      end
    end
  end

  // Storage is never reset; a write aborted by reset is dropped here too.
  always_ff @(posedge clk) begin
    if (!reset && access && rw_q && in_range) begin
      mem[addr_q[ADDR_BITS-1:0]] <= wdata_q;
    end
  end

  assign bus.Q    = rdata_q;
  assign bus.err  = err_q;
  assign bus.ack  = (state_q == StAck);
  assign bus.busy = (state_q != StIdle);

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the processor's load/store path.
- Accepts a level-held request (en, rw, addr, write data) from the datapath and services it after a fixed, parameterised wait-state latency.
- Returns a one-cycle ack, plus read data and an error flag.
- Replaces the zero-latency RAM model so the control unit can be exercised against a memory that stalls.

Parameters:
ADDR_BITS, 8, number of address bits actually decoded.
DEPTH, 256, number of 16-bit words stored; must be <= 2**ADDR_BITS.
LATENCY, 2, wait cycles between capture and ack; legal range 1..15.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  request valid; the requester holds it high until ack is seen.
rw  input  1  0 = read, 1 = write.
addr  input  16  word address; the full 16 bits are compared against DEPTH.
A  input  16  write data.
Q  output  16  read data (registered).
ack  output  1  one-cycle completion pulse (registered).
err  output  1  address out of range for the completing transaction; valid only while ack=1.
busy  output  1  high while a transaction is in progress (WAIT or ACK state).

Behaviour:
- Reset (synchronous, when reset=1 at a rising edge):
  - state=IDLE; Q=16'h0000; ack=0; err=0; busy=0; wait counter=0.
  - Storage contents are NOT cleared.
  - Reset has priority over every other event.
  - A write that is in WAIT when reset arrives is aborted and never committed.
- States: IDLE, WAIT, ACK.
- IDLE:
  - If en=1 at an edge: capture addr, rw and A into internal registers; cnt=LATENCY-1; busy=1; go to WAIT.
  - If en=0: stay in IDLE.
- WAIT:
  - Inputs en, rw, addr and A are ignored; the captured values are used.
  - If cnt != 0: decrement cnt.
  - If cnt == 0, perform the access at this edge and go to ACK with ack=1:
    - In-range write (captured addr < DEPTH): mem[addr]=A; Q unchanged; err=0.
    - In-range read: Q=mem[addr]; err=0.
    - Out of range: no storage change; Q=16'h0000 on a read (unchanged on a write); err=1.
- ACK:
  - Lasts exactly one cycle; ack=1 and busy=1.
  - At the next edge: ack=0, err=0, busy=0; go to IDLE.
  - en is not sampled in ACK.
- Latency:
  - If en is sampled at edge e0, ack is high during the cycle after edge e(LATENCY).
  - The requester sees ack at edge e(LATENCY+1).
- Throughput:
  - With en held continuously high, a new transaction is captured at the first edge back in IDLE.
  - This gives one transaction per LATENCY+2 cycles.
- Read-after-write: a read to an address written by the immediately preceding transaction returns the new data. There is no bypass hazard, because only one transaction is in flight at a time.
- Q holds its value across idle periods and writes; it changes only on a completed read or on reset.
- en deasserted during WAIT: the transaction still completes and ack still pulses; there is no abort except reset.
- Counter width: 4 bits. LATENCY=1 means cnt starts at 0, so a single WAIT cycle occurs.

Test Plan:
1. Reset, then write addr=16'h0005, A=16'hBEEF, LATENCY=2 → ack high for exactly one cycle, 2 edges after capture; err=0; Q stays 16'h0000.
2. Read addr=16'h0005 after test 1 → Q=16'hBEEF with ack, err=0; Q still 16'hBEEF 10 cycles later with en=0.
3. Read addr=16'h0100 (DEPTH=256) → ack with err=1, Q=16'h0000. Then write addr=16'h0200, A=16'h1234 → err=1, and a read of addr 16'h0000 shows no aliasing.
4. With en held high, issue a write to addr 3 (A=16'h00AA) then a read of addr 3 → first ack, then second ack 4 cycles later (LATENCY+2) with Q=16'h00AA; busy low only in the IDLE cycle between them.
5. Start a write (addr 7, A=16'h5555) and assert reset during WAIT → no ack; outputs return to reset values; a subsequent read of addr 7 returns its prior content (16'h0000 if written as 0 earlier).
6. Change addr/A/rw mid-WAIT (capture read addr 5, switch to write addr 6) → read of addr 5 completes with Q=16'hBEEF; addr 6 unmodified.
